// File: rtl/if_stage.sv
// Instruction fetch stage: REQ/WAIT/HOLD/DROP/EXC FSM with one outstanding imem request.
// Define IF_MISALIGN_EXC_EN to turn misaligned redirect targets into a fetch exception.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module if_stage #(
  parameter logic [`DATAWIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [`DATAWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect,
  input  logic [`DATAWIDTH-1:0] redirect_pc,
  input  logic                  out_allow,
  output logic                  validout,
  output logic [`DATAWIDTH-1:0] out_PC_now,
  output logic [`DATAWIDTH-1:0] out_PC_add_4,
  output logic [`DATAWIDTH-1:0] out_instr,
  output logic                  out_exc,
  output logic                  imem_req,
  output logic [`DATAWIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [`DATAWIDTH-1:0] imem_rdata
);

  localparam int unsigned DW = `DATAWIDTH;

  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, EXC} state_t;

  state_t        state_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] instr_q;
  logic [DW-1:0] pc_now_q;
  logic [DW-1:0] pc_add4_q;
  logic          exc_q;
  logic          exc_vld_q;
  logic          pend_q;

  logic [DW-1:0] pc_inc;
  logic [DW-1:0] tgt_pc;
  logic          misaligned;
  logic          inflight;

  assign pc_inc = pc_q + DW'(4);

`ifdef IF_MISALIGN_EXC_EN
  assign misaligned = |redirect_pc[1:0];
  assign tgt_pc     = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign tgt_pc     = redirect_pc & ~(DW'(3));
`endif

  // A request is still owed a response if it has not returned by the end of this cycle;
  // EXC can be entered with one pending, and it must be drained before the next fetch.
  assign inflight = ((state_q == WAIT) || (state_q == DROP) || ((state_q == EXC) && pend_q))
                    && !imem_rvalid;

  assign imem_req     = rst_n && (state_q == REQ) && !redirect;
  assign imem_addr    = pc_q;
  assign validout     = !redirect && ((state_q == HOLD) || ((state_q == EXC) && exc_vld_q));
  assign out_PC_now   = pc_now_q;
  assign out_PC_add_4 = pc_add4_q;
  assign out_instr    = instr_q;
  assign out_exc      = exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pc_now_q  <= '0;
      pc_add4_q <= '0;
      exc_q     <= 1'b0;
      exc_vld_q <= 1'b0;
      pend_q    <= 1'b0;
    end else if (redirect) begin
      pc_q <= tgt_pc;
      if (misaligned) begin
        state_q   <= EXC;
        instr_q   <= NOP_INSTR;
        pc_now_q  <= redirect_pc;
        pc_add4_q <= redirect_pc + DW'(4);
        exc_q     <= 1'b1;
        exc_vld_q <= 1'b1;
        pend_q    <= inflight;
      end else begin
        // A response arriving in the redirect cycle is discarded directly; otherwise DROP eats it.
        state_q   <= inflight ? DROP : REQ;
        exc_q     <= 1'b0;
        exc_vld_q <= 1'b0;
        pend_q    <= 1'b0;
      end
    end else begin
      unique case (state_q)
        REQ: state_q <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr_q   <= imem_rdata;
            pc_now_q  <= pc_q;
            pc_add4_q <= pc_inc;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_allow) begin
            pc_q    <= pc_inc;
            state_q <= REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) state_q <= REQ;
        end
        EXC: begin
          if (out_allow && exc_vld_q) exc_vld_q <= 1'b0;
          if (imem_rvalid) pend_q <= 1'b0;
        end
        default: state_q <= REQ;
      endcase
    end
  end

endmodule
